spi_master: RTL and testbench

SPI master that sits directly upstream of the team's SPI slave and drives its sck/ssn/mosi pins. It returns the slave's miso data to the host side. One byte is transferred per start request, MSB first. The master emits exactly 16 SCK edges inside one ssn-low window, which matches the slave's 16-edge frame count. CPOL/CPHA come from the same spcon bit positions the slave uses, so one control byte can configure both ends.

---
 rtl/spi_master.sv | 149 ++++++++++++++
 tb/tb_spi_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: one byte per start request, MSB first, 16 SCK edges per ssn-low window.
// CPOL/CPHA sit at the same spcon bit positions the companion SPI slave uses.
module spi_master #(
    parameter int SCK_HALF = 4,
    parameter int GAP_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_m,
    input  logic [7:0] spcon_m,
    input  logic       start,
    output logic       busy,
    output logic       data_finish_m,
    output logic [7:0] data_r_m,
    output logic       mosi,
    input  logic       miso,
    output logic       sck,
    output logic       ssn
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [7:0] HALF_LAST = 8'(SCK_HALF - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYC - 1);

    logic [2:0] state;
    logic [7:0] half_cnt;
    logic [4:0] edge_cnt;
    logic [2:0] bit_idx;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic       cpol_sh;
    logic       cpha_sh;

    logic       half_done;
    logic       edge_fire;
    logic       edge_odd;
    logic       sample_edge;
    logic       drive_edge;
    logic       unused_spcon;

    assign unused_spcon = ^{spcon_m[7:3], spcon_m[0], cpol_sh};

    assign half_done = (half_cnt == HALF_LAST);
    assign edge_fire = ((state == ST_SETUP) || (state == ST_XFER)) && half_done;

    // edge_cnt counts edges already produced, so the upcoming edge is odd when it is even
    assign edge_odd    = ~edge_cnt[0];
    assign sample_edge = edge_odd ^ cpha_sh;
    assign drive_edge  = cpha_sh ? edge_odd : (~edge_odd && (edge_cnt != 5'd15));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            half_cnt      <= '0;
            edge_cnt      <= '0;
            bit_idx       <= '0;
            cpol_sh       <= 1'b0;
            cpha_sh       <= 1'b0;
            ssn           <= 1'b1;
            sck           <= 1'b0;
            mosi          <= 1'b0;
            busy          <= 1'b0;
            data_finish_m <= 1'b0;
            data_r_m      <= '0;
        end else begin
            data_finish_m <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sck      <= spcon_m[2];
                    half_cnt <= '0;
                    edge_cnt <= '0;
                    if (start) begin
                        state   <= ST_SETUP;
                        ssn     <= 1'b0;
                        busy    <= 1'b1;
                        cpol_sh <= spcon_m[2];
                        cpha_sh <= spcon_m[1];
                        // cpha=0 presents bit7 up front, so the first shift edge drives bit6
                        bit_idx <= spcon_m[1] ? 3'd7 : 3'd6;
                        mosi    <= spcon_m[1] ? 1'b0 : data_m[7];
                    end
                end

                ST_SETUP, ST_XFER: begin
                    if (half_done) begin
                        half_cnt <= '0;
                        sck      <= ~sck;
                        edge_cnt <= edge_cnt + 5'd1;
                        state    <= (edge_cnt == 5'd15) ? ST_HOLD : ST_XFER;
                        if (drive_edge) begin
                            mosi    <= tx_sr[bit_idx];
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                        if (state == ST_SETUP) begin
                            edge_cnt <= '0;
                        end
                    end
                end

                ST_HOLD: begin
                    if (half_done) begin
                        half_cnt      <= '0;
                        state         <= ST_GAP;
                        ssn           <= 1'b1;
                        mosi          <= 1'b0;
                        data_r_m      <= rx_sr;
                        data_finish_m <= 1'b1;
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end

                ST_GAP: begin
                    if (half_cnt == GAP_LAST) begin
                        half_cnt <= '0;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        half_cnt <= half_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    ssn   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Shift data: loaded on acceptance, miso taken on the clk edge that makes the sampling transition
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && start) begin
            tx_sr <= data_m;
        end
        if (edge_fire && sample_edge) begin
            rx_sr <= {rx_sr[6:0], miso};
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave and optional miso loopback.
module tb_spi_master;

    localparam int H = 4;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_m;
    logic [7:0] spcon_m;
    logic       start;
    logic       busy;
    logic       data_finish_m;
    logic [7:0] data_r_m;
    logic       mosi;
    logic       miso;
    logic       sck;
    logic       ssn;

    logic       lb = 1'b0;
    logic       s_cpha = 1'b0;
    logic [7:0] data_s = 8'h00;
    logic       s_miso = 1'b0;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int         s_cnt = 0;
    logic       ssn_q = 1'b1;
    logic       sck_q = 1'b0;
    logic [7:0] got_rx [0:63];
    int         got_edges = 0;
    int         s_frames = 0;
    int         bad_toggles = 0;

    int n_vec = 0;
    int n_err = 0;

    assign miso = lb ? mosi : s_miso;

    always #5 clk = ~clk;

    spi_master #(.SCK_HALF(H), .GAP_CYC(G)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_m        (data_m),
        .spcon_m       (spcon_m),
        .start         (start),
        .busy          (busy),
        .data_finish_m (data_finish_m),
        .data_r_m      (data_r_m),
        .mosi          (mosi),
        .miso          (miso),
        .sck           (sck),
        .ssn           (ssn)
    );

    // Slave model: reacts to sck transitions seen on the falling clk edge
    always @(negedge clk) begin
        ssn_q <= ssn;
        sck_q <= sck;
        if (busy === 1'b1 && ssn === 1'b1 && sck !== sck_q)
            bad_toggles <= bad_toggles + 1;
        if (ssn_q === 1'b1 && ssn === 1'b0) begin
            s_cnt  <= 0;
            s_rx   <= 8'h00;
            s_tx   <= data_s;
            s_miso <= s_cpha ? 1'b0 : data_s[7];
        end else if (ssn === 1'b0 && sck !== sck_q) begin
            s_cnt <= s_cnt + 1;
            if ((s_cnt % 2) == 0) begin
                if (!s_cpha) s_rx <= {s_rx[6:0], mosi};
                else begin
                    s_miso <= s_tx[7];
                    s_tx   <= s_tx << 1;
                end
            end else begin
                if (!s_cpha) begin
                    s_miso <= s_tx[6];
                    s_tx   <= s_tx << 1;
                end else s_rx <= {s_rx[6:0], mosi};
            end
        end
        if (ssn_q === 1'b0 && ssn === 1'b1) begin
            got_rx[s_frames % 64] <= s_rx;
            got_edges <= s_cnt;
            s_frames  <= s_frames + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic [7:0] sp,
                             input logic [7:0] ds, input logic [7:0] exp_rx, input logic flip);
        int c, edges, first, last;
        logic sck_l;
        data_m  = d;
        spcon_m = sp;
        data_s  = ds;
        s_cpha  = sp[1];
        repeat (2) @(negedge clk);
        chk({tag, "_idle_sck"}, 32'(sck), 32'(sp[2]));
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        data_m = ~d;
        chk({tag, "_ssn_low"}, 32'(ssn), 32'd0);
        chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
        c = 0; edges = 0; first = 0; last = 0; sck_l = sck;
        while (data_finish_m !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
            if (flip && c == 20) spcon_m = 8'h04;
            if (sck !== sck_l) begin
                edges++;
                if (edges == 1) first = c;
                last  = c;
                sck_l = sck;
            end
        end
        chk({tag, "_finish_cyc"}, 32'(c), 32'(17 * H));
        chk({tag, "_ssn_high"}, 32'(ssn), 32'd1);
        chk({tag, "_end_sck"}, 32'(sck), 32'(sp[2]));
        chk({tag, "_end_mosi"}, 32'(mosi), 32'd0);
        chk({tag, "_data_r_m"}, 32'(data_r_m), 32'(exp_rx));
        chk({tag, "_edges"}, 32'(edges), 32'd16);
        chk({tag, "_first_edge"}, 32'(first), 32'(H));
        chk({tag, "_last_edge"}, 32'(last), 32'(16 * H));
        @(negedge clk);
        c++;
        chk({tag, "_finish_pulse"}, 32'(data_finish_m), 32'd0);
        while (busy === 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_busy_drop"}, 32'(c), 32'(17 * H + G));
        chk({tag, "_gap_sck"}, 32'(sck), 32'(sp[2]));
        chk({tag, "_slave_rx"}, 32'(got_rx[(s_frames - 1) % 64]), 32'(d));
        chk({tag, "_slave_edges"}, 32'(got_edges), 32'd16);
    endtask

    initial begin
        int c, edges, base, acc_n;
        int acc_i [0:3];
        logic bprev, sck_l;

        rst = 1'b1; start = 1'b0; data_m = 8'h00; spcon_m = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ssn", 32'(ssn), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(data_finish_m), 32'd0);
        chk("rst_data_r", 32'(data_r_m), 32'd0);
        rst = 1'b0;

        run_frame("m0", 8'hA5, 8'h00, 8'h3C, 8'h3C, 1'b0);
        run_frame("m3", 8'h81, 8'h06, 8'h7E, 8'h7E, 1'b0);

        // start held high while data_m changes every cycle
        base = s_frames; data_s = 8'h5A; spcon_m = 8'h00; s_cpha = 1'b0;
        repeat (2) @(negedge clk);
        acc_n = 0; bprev = busy;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            if (busy === 1'b1 && bprev !== 1'b1) begin
                if (acc_n < 4) acc_i[acc_n] = i;
                acc_n++;
            end
            bprev  = busy;
            start  = 1'b1;
            data_m = 8'(i * 37 + 5);
        end
        start = 1'b0;
        c = 0;
        while (busy === 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        repeat (20) @(negedge clk);
        chk("hold_accepts", 32'(acc_n), 32'd2);
        chk("hold_first_at", 32'(acc_i[0]), 32'd1);
        chk("hold_spacing", 32'(acc_i[1] - acc_i[0]), 32'(17 * H + G + 1));
        chk("hold_frames", 32'(s_frames - base), 32'd2);
        chk("hold_byte0", 32'(got_rx[base % 64]), 32'h05);
        chk("hold_byte1", 32'(got_rx[(base + 1) % 64]), 32'h92);
        chk("hold_data_r", 32'(data_r_m), 32'h5A);

        // reset during edge 7 of a mode 1 frame
        spcon_m = 8'h02; data_m = 8'hC3; data_s = 8'h99; s_cpha = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0; edges = 0; sck_l = sck;
        while (edges < 7 && c < 400) begin
            @(negedge clk);
            c++;
            if (sck !== sck_l) begin
                edges++;
                sck_l = sck;
            end
        end
        chk("abort_edge7", 32'(edges), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ssn", 32'(ssn), 32'd1);
        chk("abort_sck", 32'(sck), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_data_r", 32'(data_r_m), 32'd0);
        chk("abort_finish", 32'(data_finish_m), 32'd0);
        chk("abort_mosi", 32'(mosi), 32'd0);
        repeat (3) @(negedge clk);
        run_frame("m1post", 8'h3D, 8'h02, 8'hE7, 8'hE7, 1'b0);

        // mode change mid-frame: frame stays in mode 0, idle level follows after
        run_frame("flip", 8'h6B, 8'h00, 8'hD2, 8'hD2, 1'b1);
        @(negedge clk);
        chk("flip_idle_sck", 32'(sck), 32'd1);

        lb = 1'b1;
        run_frame("lb_m1", 8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0);
        run_frame("lb_m2", 8'h00, 8'h04, 8'hAA, 8'h00, 1'b0);
        lb = 1'b0;

        chk("no_ssn_high_toggles", 32'(bad_toggles), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
